// File: rtl/simon_uart_block_tx.sv
// UART block transmitter: serializes a NUM_BYTES cipher block, byte 0 first, as 8N1 frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after each byte's data bits.
module simon_uart_block_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int NUM_BYTES    = 8,
    parameter int CNT_W        = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] block_in,
    input  logic                   block_valid,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   txd_data_out
);
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [IDX_W-1:0]       byte_idx;
    logic [8*NUM_BYTES-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic                   par;
`endif

    // Current data bit always sits at shreg[0]; shifting once per data bit
    // brings the next byte down to the LSBs as the current one completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            txd_data_out <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd_data_out <= 1'b1;
                    if (block_valid) begin
                        shreg        <= block_in;
                        state        <= START;
                        cnt          <= '0;
                        byte_idx     <= '0;
                        txd_data_out <= 1'b0;
                        tx_busy      <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == LAST_CNT) begin
                        cnt          <= '0;
                        bit_idx      <= '0;
                        state        <= DATA;
                        txd_data_out <= shreg[0];
`ifdef UART_TX_PARITY_EN
                        par          <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state        <= PARITY;
                            txd_data_out <= par ^ shreg[0];
`else
                            state        <= STOP;
                            txd_data_out <= 1'b1;
`endif
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            txd_data_out <= shreg[1];
`ifdef UART_TX_PARITY_EN
                            par          <= par ^ shreg[0];
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt          <= '0;
                        state        <= STOP;
                        txd_data_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state    <= IDLE;
                            byte_idx <= '0;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            byte_idx     <= byte_idx + IDX_W'(1);
                            state        <= START;
                            txd_data_out <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    txd_data_out <= 1'b1;
                    tx_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
